// File: rtl/commit_unit_if.sv
// Shared commit-stage types plus the bundle of signals between the scoreboard head,
// the register files, the LSU and the commit unit.
package commit_pkg;
    localparam int XLEN = 32;

    typedef enum logic [2:0] {
        FU_NONE, FU_ALU, FU_BRANCH, FU_LOAD, FU_STORE, FU_CSR
    } fu_t;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, LSU_LW, LSU_SW, CSR_RW, CSR_RS, CSR_RC
    } fu_op_e;

    typedef struct packed {
        logic            valid;
        fu_t             fu;
        fu_op_e          op;
        logic [4:0]      rd;
        logic [XLEN-1:0] result;
    } decoder_t;
endpackage

interface commit_unit_if #(
    parameter int NR_COMMIT = 2,
    parameter int XLEN      = commit_pkg::XLEN
);
    import commit_pkg::*;

    logic                            halt_i;
    decoder_t [NR_COMMIT-1:0]        instr_i;
    logic     [NR_COMMIT-1:0]        commit_ack_o;
    logic     [NR_COMMIT-1:0]        gpr_we_o;
    logic     [NR_COMMIT-1:0][4:0]   gpr_waddr_o;
    logic     [NR_COMMIT-1:0][XLEN-1:0] gpr_wdata_o;
    fu_op_e                          csr_op_o;
    logic     [XLEN-1:0]             csr_wdata_o;
    logic     [XLEN-1:0]             csr_rdata_i;
    logic                            commit_csr_o;
    logic                            commit_lsu_o;
    logic                            lsu_ready_i;
    logic     [63:0]                 instret_o;

    // The commit unit drives the retire side of the bundle.
    modport master (
        input  halt_i, instr_i, csr_rdata_i, lsu_ready_i,
        output commit_ack_o, gpr_we_o, gpr_waddr_o, gpr_wdata_o,
               csr_op_o, csr_wdata_o, commit_csr_o, commit_lsu_o, instret_o
    );

    modport slave (
        output halt_i, instr_i, csr_rdata_i, lsu_ready_i,
        input  commit_ack_o, gpr_we_o, gpr_waddr_o, gpr_wdata_o,
               csr_op_o, csr_wdata_o, commit_csr_o, commit_lsu_o, instret_o
    );
endinterface

// File: rtl/commit_unit.sv
// Multi-port in-order commit: retires a contiguous prefix of the scoreboard head each
// cycle, serialises after CSR commits and counts retired instructions.
module commit_unit
    import commit_pkg::*;
#(
    parameter int NR_COMMIT = 2,
    parameter int CSR_STALL = 2,
    parameter int XLEN      = commit_pkg::XLEN
) (
    input  logic           clk,
    input  logic           rst,
    commit_unit_if.master  cif
);
    localparam int CW = (CSR_STALL > 1) ? $clog2(CSR_STALL) : 1;

    typedef enum logic {IDLE, CSR_BLOCK} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [63:0]   instret_q, instret_d;

    logic [NR_COMMIT-1:0]           ack;
    logic [NR_COMMIT-1:0]           we;
    logic [NR_COMMIT-1:0][4:0]      waddr;
    logic [NR_COMMIT-1:0][XLEN-1:0] wdata;
    fu_op_e                         csr_op;
    logic [XLEN-1:0]                csr_wdata;
    logic                           commit_csr;
    logic                           lsu_taken;
    logic                           chain;
    logic                           can_commit;
    logic                           is_lsu;
    logic                           ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            instret_q <= instret_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        instret_d  = instret_q;
        ack        = '0;
        we         = '0;
        waddr      = '0;
        wdata      = '0;
        csr_op     = ALU_ADD;
        csr_wdata  = '0;
        commit_csr = 1'b0;
        lsu_taken  = 1'b0;
        chain      = 1'b1;
        is_lsu     = 1'b0;
        ok         = 1'b0;
        can_commit = (state_q == IDLE) && !cif.halt_i && !rst;

        // Ack chain: each port may retire only if every older port retires too.
        for (int i = 0; i < NR_COMMIT; i++) begin
            is_lsu = (cif.instr_i[i].fu == FU_LOAD) || (cif.instr_i[i].fu == FU_STORE);
            ok     = !((i != 0) && (cif.instr_i[i].fu == FU_CSR))
                  && !((i != 0) && (cif.instr_i[0].fu == FU_CSR))
                  && !(is_lsu && (lsu_taken || !cif.lsu_ready_i));
            ack[i] = chain && can_commit && cif.instr_i[i].valid && ok;
            chain  = ack[i];
            if (ack[i] && is_lsu)
                lsu_taken = 1'b1;
            if (ack[i])
                instret_d = instret_d + 64'd1;
            waddr[i] = cif.instr_i[i].rd;
            wdata[i] = cif.instr_i[i].result;
        end

        // A younger port writing the same register supersedes the older write.
        for (int i = 0; i < NR_COMMIT; i++) begin
            we[i] = ack[i] && (cif.instr_i[i].rd != 5'd0);
            for (int j = i + 1; j < NR_COMMIT; j++) begin
                if (ack[j] && (cif.instr_i[j].rd == cif.instr_i[i].rd))
                    we[i] = 1'b0;
            end
        end

        if (ack[0] && (cif.instr_i[0].fu == FU_CSR)) begin
            commit_csr = 1'b1;
            csr_op     = cif.instr_i[0].op;
            csr_wdata  = cif.instr_i[0].result;
            wdata[0]   = cif.csr_rdata_i;
        end

        case (state_q)
            IDLE: begin
                if (commit_csr) begin
                    state_d = CSR_BLOCK;
                    cnt_d   = CW'(CSR_STALL - 1);
                end
            end
            CSR_BLOCK: begin
                if (cnt_q == '0)
                    state_d = IDLE;
                else
                    cnt_d = cnt_q - CW'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    assign cif.commit_ack_o = ack;
    assign cif.gpr_we_o     = we;
    assign cif.gpr_waddr_o  = waddr;
    assign cif.gpr_wdata_o  = wdata;
    assign cif.csr_op_o     = csr_op;
    assign cif.csr_wdata_o  = csr_wdata;
    assign cif.commit_csr_o = commit_csr;
    assign cif.commit_lsu_o = lsu_taken;
    assign cif.instret_o    = instret_q;
endmodule

// File: tb/tb_commit_unit.sv
// Directed checks of commit_unit with two ports and a two-cycle CSR stall.
module tb_commit_unit;
    import commit_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    commit_unit_if #(.NR_COMMIT(2), .XLEN(32)) cif ();

    commit_unit #(.NR_COMMIT(2), .CSR_STALL(2), .XLEN(32)) dut (
        .clk (clk),
        .rst (rst),
        .cif (cif)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_port(input int idx, input logic v, input fu_t fu, input fu_op_e op,
                            input logic [4:0] rd, input logic [31:0] res);
        decoder_t d;
        d.valid  = v;
        d.fu     = fu;
        d.op     = op;
        d.rd     = rd;
        d.result = res;
        cif.instr_i[idx] = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst             = 1'b1;
        cif.halt_i      = 1'b0;
        cif.csr_rdata_i = 32'h55;
        cif.lsu_ready_i = 1'b1;
        set_port(0, 1'b1, FU_ALU, ALU_ADD, 5'd3, 32'h11);
        set_port(1, 1'b1, FU_ALU, ALU_SUB, 5'd4, 32'h22);
        tick();
        tick();
        #1;
        chk("rst_ack", cif.commit_ack_o, 2'b00);
        chk("rst_we", cif.gpr_we_o, 2'b00);
        chk("rst_csr_op", cif.csr_op_o, ALU_ADD);
        chk("rst_instret", cif.instret_o, 64'd0);
        $display("step reset: ack=%b instret=%0d", cif.commit_ack_o, cif.instret_o);

        // Two ALU ops retire together
        rst = 1'b0;
        #1;
        chk("alu2_ack", cif.commit_ack_o, 2'b11);
        chk("alu2_we", cif.gpr_we_o, 2'b11);
        chk("alu2_wdata0", cif.gpr_wdata_o[0], 32'h11);
        chk("alu2_waddr1", cif.gpr_waddr_o[1], 5'd4);
        chk("alu2_instret_pre", cif.instret_o, 64'd0);
        tick();
        chk("alu2_instret_post", cif.instret_o, 64'd2);
        $display("step alu2: ack=%b instret=%0d", cif.commit_ack_o, cif.instret_o);

        // CSR on port 1 must wait for port 0
        set_port(0, 1'b1, FU_ALU, ALU_ADD, 5'd1, 32'h33);
        set_port(1, 1'b1, FU_CSR, CSR_RW, 5'd5, 32'hAB);
        #1;
        chk("csr_p1_ack", cif.commit_ack_o, 2'b01);
        chk("csr_p1_commit_csr", cif.commit_csr_o, 1'b0);
        tick();
        chk("csr_p1_instret", cif.instret_o, 64'd3);
        $display("step csr_p1: instret=%0d", cif.instret_o);

        set_port(0, 1'b1, FU_CSR, CSR_RW, 5'd5, 32'hAB);
        set_port(1, 1'b1, FU_ALU, ALU_ADD, 5'd6, 32'h44);
        #1;
        chk("csr_p0_ack", cif.commit_ack_o, 2'b01);
        chk("csr_p0_commit_csr", cif.commit_csr_o, 1'b1);
        chk("csr_p0_op", cif.csr_op_o, CSR_RW);
        chk("csr_p0_wdata", cif.csr_wdata_o, 32'hAB);
        chk("csr_p0_gpr_wdata", cif.gpr_wdata_o[0], 32'h55);
        chk("csr_p0_we", cif.gpr_we_o, 2'b01);
        $display("step csr_p0: ack=%b commit_csr=%b", cif.commit_ack_o, cif.commit_csr_o);
        tick();

        set_port(0, 1'b1, FU_ALU, ALU_ADD, 5'd2, 32'h66);
        set_port(1, 1'b1, FU_ALU, ALU_ADD, 5'd6, 32'h44);
        #1;
        chk("stall1_ack", cif.commit_ack_o, 2'b00);
        chk("stall1_instret", cif.instret_o, 64'd4);
        tick();
        chk("stall2_ack", cif.commit_ack_o, 2'b00);
        tick();
        chk("resume_ack", cif.commit_ack_o, 2'b11);
        $display("step stall/resume: ack=%b", cif.commit_ack_o);
        tick();
        chk("resume_instret", cif.instret_o, 64'd6);

        // LSU: one per cycle, gated by lsu_ready_i
        set_port(0, 1'b1, FU_STORE, LSU_SW, 5'd0, 32'h100);
        set_port(1, 1'b1, FU_LOAD, LSU_LW, 5'd8, 32'h200);
        #1;
        chk("lsu_ack", cif.commit_ack_o, 2'b01);
        chk("lsu_commit", cif.commit_lsu_o, 1'b1);
        chk("lsu_we", cif.gpr_we_o, 2'b00);
        cif.lsu_ready_i = 1'b0;
        #1;
        chk("lsu_nready_ack", cif.commit_ack_o, 2'b00);
        chk("lsu_nready_commit", cif.commit_lsu_o, 1'b0);
        $display("step lsu: ack=%b commit_lsu=%b", cif.commit_ack_o, cif.commit_lsu_o);
        tick();
        chk("lsu_instret", cif.instret_o, 64'd6);
        cif.lsu_ready_i = 1'b1;

        // Same destination on both ports; rd=0 on port 0
        set_port(0, 1'b1, FU_ALU, ALU_ADD, 5'd7, 32'h1);
        set_port(1, 1'b1, FU_ALU, ALU_ADD, 5'd7, 32'h2);
        #1;
        chk("samerd_ack", cif.commit_ack_o, 2'b11);
        chk("samerd_we", cif.gpr_we_o, 2'b10);
        tick();
        set_port(0, 1'b1, FU_ALU, ALU_ADD, 5'd0, 32'h1);
        set_port(1, 1'b1, FU_ALU, ALU_ADD, 5'd9, 32'h2);
        #1;
        chk("rd0_ack", cif.commit_ack_o, 2'b11);
        chk("rd0_we", cif.gpr_we_o, 2'b10);
        $display("step rd: ack=%b we=%b", cif.commit_ack_o, cif.gpr_we_o);
        tick();
        chk("rd_instret", cif.instret_o, 64'd10);

        // Invalid head blocks younger; halt blocks everything
        set_port(0, 1'b0, FU_ALU, ALU_ADD, 5'd1, 32'h1);
        set_port(1, 1'b1, FU_ALU, ALU_ADD, 5'd2, 32'h2);
        #1;
        chk("inv0_ack", cif.commit_ack_o, 2'b00);
        tick();
        set_port(0, 1'b1, FU_ALU, ALU_ADD, 5'd1, 32'h1);
        cif.halt_i = 1'b1;
        #1;
        chk("halt_ack", cif.commit_ack_o, 2'b00);
        tick();
        chk("halt_instret", cif.instret_o, 64'd10);
        $display("step halt: ack=%b instret=%0d", cif.commit_ack_o, cif.instret_o);
        cif.halt_i = 1'b0;

        // Reset in the middle of a CSR stall
        set_port(0, 1'b1, FU_CSR, CSR_RS, 5'd5, 32'hCD);
        set_port(1, 1'b0, FU_ALU, ALU_ADD, 5'd0, 32'h0);
        #1;
        chk("rst_csr_commit", cif.commit_csr_o, 1'b1);
        tick();
        rst = 1'b1;
        #1;
        chk("rstblk_ack", cif.commit_ack_o, 2'b00);
        chk("rstblk_commit_csr", cif.commit_csr_o, 1'b0);
        chk("rstblk_csr_op", cif.csr_op_o, ALU_ADD);
        chk("rstblk_csr_wdata", cif.csr_wdata_o, 32'h0);
        tick();
        chk("rstblk_instret", cif.instret_o, 64'd0);
        rst = 1'b0;
        set_port(0, 1'b1, FU_ALU, ALU_ADD, 5'd1, 32'h1);
        set_port(1, 1'b1, FU_ALU, ALU_ADD, 5'd2, 32'h2);
        #1;
        chk("rstblk_idle_ack", cif.commit_ack_o, 2'b11);
        $display("step reset_mid_stall: ack=%b instret=%0d", cif.commit_ack_o, cif.instret_o);

        // Counter wrap
        force dut.instret_q = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        release dut.instret_q;
        #1;
        chk("wrap_pre", cif.instret_o, 64'hFFFF_FFFF_FFFF_FFFF);
        tick();
        chk("wrap_post", cif.instret_o, 64'd1);
        $display("step wrap: instret=%0d", cif.instret_o);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
